// File: rtl/fp_prenorm_pkg.sv
// ============================================================================
// Module  : fp_prenorm_pkg
// Brief   : Shared types, field widths and operand classifier for the FIR
//           floating-point operand pre-normalization path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_prenorm_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int XEXP_W = 10;

  // Bit positions inside the 2-bit {special, zero} flag field
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_SPECIAL = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHA  = 2'd1,
    SHB  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [XEXP_W-1:0] exp;
    logic [1:0]        flags;
    logic              sub;
  } class_t;

  // Bypass classification; subnormals come back with sub=1 and zeroed
  // mant/exp that the shared shift unit overwrites later.
  function automatic class_t classify(input logic [31:0] x);
    class_t            c;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e       = x[30:23];
    f       = x[22:0];
    c.mant  = {1'b1, f};
    c.exp   = {2'b00, e};
    c.flags = 2'b00;
    c.sub   = 1'b0;
    if (e == 8'hFF) begin
      c.mant                = {1'b0, f};
      c.flags[FLAG_SPECIAL] = 1'b1;
    end else if (e == 8'h00) begin
      c.mant = '0;
      c.exp  = '0;
      if (f == '0) begin
        c.flags[FLAG_ZERO] = 1'b1;
      end else begin
        c.sub = 1'b1;
      end
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prenorm_lzc.sv
// ============================================================================
// Module  : prenorm_lzc
// Brief   : Leading-one shift counter plus left shifter for one subnormal
//           fraction; yields a mantissa with the hidden bit at [23] and the
//           matching widened exponent (1 - shift).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prenorm_lzc
  import fp_prenorm_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  output logic [MANT_W-1:0] norm_mant,
  output logic [XEXP_W-1:0] norm_exp
);

  logic [4:0] shift;

  // Highest set bit wins: later (higher) indices override lower ones
  always_comb begin
    shift = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (frac[i]) begin
        shift = 5'(FRAC_W - i);
      end
    end
    norm_mant = {1'b0, frac} << shift;
    norm_exp  = XEXP_W'(1) - XEXP_W'(shift);
  end

endmodule

`default_nettype wire

// File: rtl/prenorm_sched.sv
// ============================================================================
// Module  : prenorm_sched
// Brief   : Accepts an IEEE-754 single operand pair, normalizes subnormal
//           operands through one time-shared shift unit and presents the
//           normalized pair with widened exponents downstream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prenorm_sched
  import fp_prenorm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign_a,
  output logic [MANT_W-1:0] out_mant_a,
  output logic [XEXP_W-1:0] out_exp_a,
  output logic [1:0]        out_flags_a,
  output logic              out_sign_b,
  output logic [MANT_W-1:0] out_mant_b,
  output logic [XEXP_W-1:0] out_exp_b,
  output logic [1:0]        out_flags_b,
  output logic [CNT_W-1:0]  denorm_cnt
);

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [FRAC_W-1:0]   frac_a_q, frac_a_d, frac_b_q, frac_b_d;
  logic                sub_b_q, sub_b_d;
  logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [MANT_W-1:0]   mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic [XEXP_W-1:0]   exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [1:0]          flags_a_q, flags_a_d, flags_b_q, flags_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  class_t              cls_a, cls_b;
  logic [FRAC_W-1:0]   lzc_frac;
  logic [MANT_W-1:0]   lzc_mant;
  logic [XEXP_W-1:0]   lzc_exp;

  // Shared unit sees b only while in SHB; otherwise it looks at a
  always_comb begin
    lzc_frac = (state_q == SHB) ? frac_b_q : frac_a_q;
  end

  prenorm_lzc u_lzc (
    .frac      (lzc_frac),
    .norm_mant (lzc_mant),
    .norm_exp  (lzc_exp)
  );

  // Next-state, datapath capture and saturating subnormal count
  always_comb begin
    cls_a     = classify(in_a);
    cls_b     = classify(in_b);
    state_d   = state_q;
    frac_a_d  = frac_a_q;
    frac_b_d  = frac_b_q;
    sub_b_d   = sub_b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    mant_a_d  = mant_a_q;
    mant_b_d  = mant_b_q;
    exp_a_d   = exp_a_q;
    exp_b_d   = exp_b_q;
    flags_a_d = flags_a_q;
    flags_b_d = flags_b_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          frac_a_d  = in_a[22:0];
          frac_b_d  = in_b[22:0];
          sub_b_d   = cls_b.sub;
          sign_a_d  = in_a[31];
          sign_b_d  = in_b[31];
          mant_a_d  = cls_a.mant;
          mant_b_d  = cls_b.mant;
          exp_a_d   = cls_a.exp;
          exp_b_d   = cls_b.exp;
          flags_a_d = cls_a.flags;
          flags_b_d = cls_b.flags;
          if (cls_a.sub) begin
            state_d = SHA;
          end else if (cls_b.sub) begin
            state_d = SHB;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHA: begin
        mant_a_d = lzc_mant;
        exp_a_d  = lzc_exp;
        state_d  = sub_b_q ? SHB : DONE;
      end
      SHB: begin
        mant_b_d = lzc_mant;
        exp_b_d  = lzc_exp;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (((state_q == SHA) || (state_q == SHB)) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset overrides any in-flight pair
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      frac_a_q    <= '0;
      frac_b_q    <= '0;
      sub_b_q     <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      mant_a_q    <= '0;
      mant_b_q    <= '0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      flags_a_q   <= '0;
      flags_b_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      frac_a_q    <= frac_a_d;
      frac_b_q    <= frac_b_d;
      sub_b_q     <= sub_b_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      mant_a_q    <= mant_a_d;
      mant_b_q    <= mant_b_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      flags_a_q   <= flags_a_d;
      flags_b_q   <= flags_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sign_a  = sign_a_q;
  assign out_mant_a  = mant_a_q;
  assign out_exp_a   = exp_a_q;
  assign out_flags_a = flags_a_q;
  assign out_sign_b  = sign_b_q;
  assign out_mant_b  = mant_b_q;
  assign out_exp_b   = exp_b_q;
  assign out_flags_b = flags_b_q;
  assign denorm_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prenorm_sched.sv
// ============================================================================
// Module  : tb_prenorm_sched
// Brief   : Directed self-checking bench for prenorm_sched (CNT_W=2 so the
//           saturating counter can be reached quickly).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prenorm_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign_a, out_sign_b;
  logic [23:0] out_mant_a, out_mant_b;
  logic [9:0]  out_exp_a, out_exp_b;
  logic [1:0]  out_flags_a, out_flags_b;
  logic [1:0]  denorm_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prenorm_sched #(.CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign_a  (out_sign_a),
    .out_mant_a  (out_mant_a),
    .out_exp_a   (out_exp_a),
    .out_flags_a (out_flags_a),
    .out_sign_b  (out_sign_b),
    .out_mant_b  (out_mant_b),
    .out_exp_b   (out_exp_b),
    .out_flags_b (out_flags_b),
    .denorm_cnt  (denorm_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present a pair for one accept edge; lat counts edges from accept to
  // out_valid (accept edge = 1). lat=-1 means out_valid never came.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, output int lat);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({out_sign_a, out_mant_a, out_exp_a, out_flags_a, out_sign_b, out_mant_b, out_exp_b, out_flags_b} !== '0)
      begin n_fail++; $display("FAIL reset_fields: got a=%h/%h b=%h/%h want 0", out_mant_a, out_exp_a, out_mant_b, out_exp_b); end
    n_cmp++; if (denorm_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", denorm_cnt); end
  endtask

  task automatic test_normal();
    int lat;
    send_pair(32'h3F80_0000, 32'h4000_0000, lat);
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL normal_latency: got %0d want 1", lat); end
    n_cmp++; if (out_mant_a !== 24'h800000 || out_exp_a !== 10'd127 || out_flags_a !== 2'b00)
      begin n_fail++; $display("FAIL normal_a: got %h/%h/%b want 800000/07f/00", out_mant_a, out_exp_a, out_flags_a); end
    n_cmp++; if (out_mant_b !== 24'h800000 || out_exp_b !== 10'd128 || out_flags_b !== 2'b00)
      begin n_fail++; $display("FAIL normal_b: got %h/%h/%b want 800000/080/00", out_mant_b, out_exp_b, out_flags_b); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL normal_in_ready_done: got %b want 0", in_ready); end
    n_cmp++; if (denorm_cnt !== 2'd0) begin n_fail++; $display("FAIL normal_cnt: got %0d want 0", denorm_cnt); end
    drain();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL normal_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_both_subnormal();
    int lat;
    do_reset();
    send_pair(32'h0040_0000, 32'h0000_0001, lat);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL sub2_latency: got %0d want 3", lat); end
    n_cmp++; if (out_mant_a !== 24'h800000 || out_exp_a !== 10'h000 || out_flags_a !== 2'b00)
      begin n_fail++; $display("FAIL sub2_a: got %h/%h/%b want 800000/000/00", out_mant_a, out_exp_a, out_flags_a); end
    n_cmp++; if (out_mant_b !== 24'h800000 || out_exp_b !== 10'h3EA || out_flags_b !== 2'b00)
      begin n_fail++; $display("FAIL sub2_b: got %h/%h/%b want 800000/3ea/00", out_mant_b, out_exp_b, out_flags_b); end
    n_cmp++; if (denorm_cnt !== 2'd2) begin n_fail++; $display("FAIL sub2_cnt: got %0d want 2", denorm_cnt); end
    drain();
  endtask

  task automatic test_zero_special();
    int lat;
    send_pair(32'h8000_0000, 32'h7FC0_0000, lat);
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL zs_latency: got %0d want 1", lat); end
    n_cmp++; if (out_sign_a !== 1'b1 || out_mant_a !== 24'h0 || out_exp_a !== 10'h0 || out_flags_a !== 2'b01)
      begin n_fail++; $display("FAIL zs_a: got %b/%h/%h/%b want 1/000000/000/01", out_sign_a, out_mant_a, out_exp_a, out_flags_a); end
    n_cmp++; if (out_sign_b !== 1'b0 || out_mant_b !== 24'h400000 || out_exp_b !== 10'h0FF || out_flags_b !== 2'b10)
      begin n_fail++; $display("FAIL zs_b: got %b/%h/%h/%b want 0/400000/0ff/10", out_sign_b, out_mant_b, out_exp_b, out_flags_b); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    send_pair(32'h3F80_0000, 32'h0000_0003, lat);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lat); end
    // A competing pair waits at the input while the result is stalled
    in_a     = 32'h4040_0000;
    in_b     = 32'hC040_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mant_b !== 24'hC00000 || out_exp_b !== 10'h3EB ||
                   out_mant_a !== 24'h800000 || out_exp_a !== 10'd127)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%b a=%h/%h b=%h/%h want 1/0 800000/07f c00000/3eb",
                                 i, out_valid, in_ready, out_mant_a, out_exp_a, out_mant_b, out_exp_b); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_release: got r=%b v=%b want 1/0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_mant_a !== 24'hC00000 || out_exp_a !== 10'd128 || out_sign_b !== 1'b1)
      begin n_fail++; $display("FAIL bp_second: got v=%b a=%h/%h sb=%b want 1 c00000/080 1", out_valid, out_mant_a, out_exp_a, out_sign_b); end
    n_cmp++; if (denorm_cnt !== 2'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d want 1", denorm_cnt); end
    drain();
  endtask

  task automatic test_reset_midop();
    in_a     = 32'h0000_0010;
    in_b     = 32'h3F80_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_busy: got r=%b v=%b want 0/0", in_ready, out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || denorm_cnt !== 2'd0)
      begin n_fail++; $display("FAIL mid_ctrl: got r=%b v=%b cnt=%0d want 1/0/0", in_ready, out_valid, denorm_cnt); end
    n_cmp++; if ({out_sign_a, out_mant_a, out_exp_a, out_flags_a, out_sign_b, out_mant_b, out_exp_b, out_flags_b} !== '0)
      begin n_fail++; $display("FAIL mid_fields: got a=%h/%h b=%h/%h want 0", out_mant_a, out_exp_a, out_mant_b, out_exp_b); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_output: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [1:0]  vc [4];
    int          lat;
    va = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0100, 32'h0000_0001};
    vb = '{32'h3F80_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001};
    vc = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_pair(va[i], vb[i], lat);
      n_cmp++; if (denorm_cnt !== vc[i] || lat < 0)
        begin n_fail++; $display("FAIL sat[%0d]: got cnt=%0d lat=%0d want cnt=%0d", i, denorm_cnt, lat, vc[i]); end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_both_subnormal();
    test_zero_special();
    test_backpressure();
    test_reset_midop();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
